// File: rtl/synth_clk_pkg.sv
// Shared clock-rate constants and divider helpers for the synth's low-rate timing blocks.
package synth_clk_pkg;

  localparam int unsigned SYS_CLK_HZ  = 50_000_000;
  localparam int unsigned CTRL_CLK_HZ = 100;

  function automatic int unsigned half_period(input int unsigned in_hz, input int unsigned out_hz);
    return (out_hz == 0) ? 0 : in_hz / (2 * out_hz);
  endfunction

  // A ratio is usable only if it gives a whole, non-zero number of input cycles per half period.
  function automatic bit ratio_ok(input int unsigned in_hz, input int unsigned out_hz);
    if (out_hz == 0) return 1'b0;
    if ((in_hz % (2 * out_hz)) != 0) return 1'b0;
    return half_period(in_hz, out_hz) >= 1;
  endfunction

  // Keeps the counter at least one bit wide so the divide-by-2 corner still elaborates.
  function automatic int unsigned cnt_width(input int unsigned hp);
    return (hp > 1) ? $clog2(hp) : 1;
  endfunction

endpackage

// File: rtl/clock_divider_50mhz_to_100hz.sv
// Divides the board clock to a 50 % duty square wave driven straight from a flop.
// Consumers must treat CLK_100Hz as a clock or enable, never gate it combinationally.
module clock_divider_50mhz_to_100hz
  import synth_clk_pkg::*;
#(
  parameter int unsigned CLK_IN_HZ  = SYS_CLK_HZ,
  parameter int unsigned CLK_OUT_HZ = CTRL_CLK_HZ
) (
  input  logic CLK_50_MHz,
  input  logic reset_n,
  output logic CLK_100Hz
);

  localparam int unsigned HALF_PERIOD = half_period(CLK_IN_HZ, CLK_OUT_HZ);
  localparam int unsigned CNT_W       = cnt_width(HALF_PERIOD);
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(HALF_PERIOD - 1);

  if (!ratio_ok(CLK_IN_HZ, CLK_OUT_HZ)) begin : g_bad_ratio
    $fatal(1, "clock_divider_50mhz_to_100hz: CLK_IN_HZ must be a non-zero multiple of 2*CLK_OUT_HZ");
  end

  logic [CNT_W-1:0] count;

  // Count runs 0..HALF_PERIOD-1 only; reset is the sole way to re-align the phase.
  always_ff @(posedge CLK_50_MHz or negedge reset_n) begin
    if (!reset_n) begin
      count     <= '0;
      CLK_100Hz <= 1'b0;
    end else if (count == LAST) begin
      count     <= '0;
      CLK_100Hz <= ~CLK_100Hz;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: tb/tb_clock_divider_50mhz_to_100hz.sv
// Bench for the clock divider at scaled-down ratios (half period 25 and the divide-by-2 corner).
module tb_clock_divider_50mhz_to_100hz;

  localparam int unsigned HP_A = 25;
  localparam int unsigned HP_B = 1;

  logic clk = 1'b0;
  bit   clk_en = 1'b0;
  logic reset_n;
  logic out_a;
  logic out_b;

  int n_checks = 0;
  int n_pass   = 0;
  int edge_cnt = 0;

  logic [31:0] exp_q[$];
  logic [31:0] rise_q[$];

  clock_divider_50mhz_to_100hz #(.CLK_IN_HZ(5000), .CLK_OUT_HZ(100)) u_div_a (
    .CLK_50_MHz(clk),
    .reset_n   (reset_n),
    .CLK_100Hz (out_a)
  );

  clock_divider_50mhz_to_100hz #(.CLK_IN_HZ(200), .CLK_OUT_HZ(100)) u_div_b (
    .CLK_50_MHz(clk),
    .reset_n   (reset_n),
    .CLK_100Hz (out_b)
  );

  // Clock / reset block: 20-unit period, clock held idle until enabled.
  always #10 if (clk_en) clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

  // Reference: after n rising edges since release, the output has toggled floor(n/hp) times.
  function automatic logic model_out(input int n, input int unsigned hp);
    return ((n / int'(hp)) % 2) == 1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    edge_cnt++;
  endtask

  task automatic release_reset();
    @(negedge clk);
    #3;
    reset_n  = 1'b1;
    edge_cnt = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #3;
    n_checks++;
    if (out_a !== 1'b0) $display("FAIL por_a: got %b want 0", out_a);
    else n_pass++;
    n_checks++;
    if (out_b !== 1'b0) $display("FAIL por_b: got %b want 0", out_b);
    else n_pass++;
    clk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (out_a !== 1'b0 || out_b !== 1'b0)
      $display("FAIL reset_held_clocking: got a=%b b=%b want 0 0", out_a, out_b);
    else n_pass++;
  endtask

  task automatic test_first_edge();
    logic prev;
    release_reset();
    prev = 1'b0;
    exp_q.delete();
    rise_q.delete();
    for (int k = 0; k < 3; k++) exp_q.push_back(32'(HP_A * (2 * k + 1)));
    for (int i = 0; i < 6 * int'(HP_A); i++) begin
      step();
      n_checks++;
      if (out_a !== model_out(edge_cnt, HP_A))
        $display("FAIL steady_a edge %0d: got %b want %b", edge_cnt, out_a, model_out(edge_cnt, HP_A));
      else n_pass++;
      n_checks++;
      if (out_b !== model_out(edge_cnt, HP_B))
        $display("FAIL steady_b edge %0d: got %b want %b", edge_cnt, out_b, model_out(edge_cnt, HP_B));
      else n_pass++;
      if (out_a === 1'b1 && prev === 1'b0) rise_q.push_back(32'(edge_cnt));
      prev = out_a;
    end
    n_checks++;
    if (rise_q.size() != exp_q.size())
      $display("FAIL rise_count: got %0d want %0d", rise_q.size(), exp_q.size());
    else n_pass++;
    while (exp_q.size() > 0 && rise_q.size() > 0) begin
      logic [31:0] e;
      logic [31:0] r;
      e = exp_q.pop_front();
      r = rise_q.pop_front();
      n_checks++;
      if (r !== e) $display("FAIL rise_edge: got %0d want %0d", r, e);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid(input logic want, input string name);
    int steps;
    int guard;
    int rise;
    steps = $urandom_range(1, 2 * HP_A);
    guard = 0;
    repeat (steps) begin
      step();
      n_checks++;
      if (out_a !== model_out(edge_cnt, HP_A) || out_b !== model_out(edge_cnt, HP_B))
        $display("FAIL %s_run edge %0d: got a=%b b=%b want a=%b b=%b", name, edge_cnt, out_a, out_b,
                 model_out(edge_cnt, HP_A), model_out(edge_cnt, HP_B));
      else n_pass++;
    end
    while (model_out(edge_cnt, HP_A) != want && guard < 2 * int'(HP_A)) begin
      step();
      guard++;
    end
    n_checks++;
    if (out_a !== want) $display("FAIL %s_phase: got %b want %b", name, out_a, want);
    else n_pass++;
    #($urandom_range(2, 17));
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (out_a !== 1'b0 || out_b !== 1'b0)
      $display("FAIL %s_async_clear: got a=%b b=%b want 0 0", name, out_a, out_b);
    else n_pass++;
    repeat ($urandom_range(1, 3)) @(posedge clk);
    #1;
    n_checks++;
    if (out_a !== 1'b0 || out_b !== 1'b0)
      $display("FAIL %s_hold: got a=%b b=%b want 0 0", name, out_a, out_b);
    else n_pass++;
    release_reset();
    rise = -1;
    for (int i = 0; i < 2 * int'(HP_A); i++) begin
      step();
      n_checks++;
      if (out_a !== model_out(edge_cnt, HP_A) || out_b !== model_out(edge_cnt, HP_B))
        $display("FAIL %s_restart edge %0d: got a=%b b=%b want a=%b b=%b", name, edge_cnt, out_a, out_b,
                 model_out(edge_cnt, HP_A), model_out(edge_cnt, HP_B));
      else n_pass++;
      if (out_a === 1'b1 && rise < 0) rise = edge_cnt;
    end
    n_checks++;
    if (rise != int'(HP_A)) $display("FAIL %s_first_rise: got %0d want %0d", name, rise, HP_A);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_first_edge();
    test_reset_mid(1'b1, "mid_high");
    test_reset_mid(1'b0, "mid_low");
    for (int i = 0; i < 4; i++) begin
      logic lvl;
      lvl = 1'($urandom_range(0, 1));
      test_reset_mid(lvl, "random");
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
